// File: rtl/game_pkg.sv
// Shared types and default key codes for the game screen controller and menu logic.
package game_pkg;

  typedef enum logic [2:0] {
    START    = 3'd0,
    PLAY     = 3'd1,
    PAUSE    = 3'd2,
    DYING    = 3'd3,
    GAMEOVER = 3'd4,
    WIN      = 3'd5
  } state_e;

  localparam logic [15:0] KEY_ENTER = 16'h0028;
  localparam logic [15:0] KEY_ESC   = 16'h0029;
  localparam logic [15:0] KEY_SPACE = 16'h002C;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Bundle between the keyboard/collision sources and the screen controller.
interface game_state_ctrl_if #(
  parameter int KEY_W   = 16,
  parameter int LIVES_W = 2
);

  logic [KEY_W-1:0]   keyboard;
  logic               pacDeath;
  logic               winsignal;
  logic               startscreen;
  logic               gamescreen;
  logic               pausescreen;
  logic               gameoverscreen;
  logic               winscreen;
  logic               game_run;
  logic               new_game;
  logic               respawn;
  logic [LIVES_W-1:0] lives_left;

  // The master side supplies keys and game events; the slave is the controller.
  modport master (
    output keyboard, pacDeath, winsignal,
    input  startscreen, gamescreen, pausescreen, gameoverscreen, winscreen,
           game_run, new_game, respawn, lives_left
  );

  modport slave (
    input  keyboard, pacDeath, winsignal,
    output startscreen, gamescreen, pausescreen, gameoverscreen, winscreen,
           game_run, new_game, respawn, lives_left
  );

endinterface

// File: rtl/key_edge.sv
// Turns a level scan code into single-cycle press strobes for three key codes.
module key_edge #(
  parameter int               KEY_W = 16,
  parameter logic [KEY_W-1:0] CODE0 = 16'h0028,
  parameter logic [KEY_W-1:0] CODE1 = 16'h0029,
  parameter logic [KEY_W-1:0] CODE2 = 16'h002C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_i,
  output logic [2:0]       press_o
);

  logic [KEY_W-1:0] key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else begin
      key_q <= key_i;
    end
  end

  // A held key only counts once; a re-press needs a different code in between.
  assign press_o[0] = (key_i == CODE0) && (key_q != CODE0);
  assign press_o[1] = (key_i == CODE1) && (key_q != CODE1);
  assign press_o[2] = (key_i == CODE2) && (key_q != CODE2);

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level screen FSM: start/play/pause/dying/game-over/win with lives and a timed death.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int               KEY_W        = 16,
  parameter logic [KEY_W-1:0] KEY_START    = KEY_ENTER,
  parameter logic [KEY_W-1:0] KEY_PAUSE    = KEY_ESC,
  parameter logic [KEY_W-1:0] KEY_ACK      = KEY_SPACE,
  parameter int               LIVES        = 3,
  parameter int               LIVES_W      = 2,
  parameter int               DEATH_CYCLES = 60,
  parameter int               TMR_W        = 8
) (
  input logic               Clk,
  input logic               Reset_n,
  game_state_ctrl_if.slave  bus
);

  localparam logic [2:0] S_START    = START;
  localparam logic [2:0] S_PLAY     = PLAY;
  localparam logic [2:0] S_PAUSE    = PAUSE;
  localparam logic [2:0] S_DYING    = DYING;
  localparam logic [2:0] S_GAMEOVER = GAMEOVER;
  localparam logic [2:0] S_WIN      = WIN;

  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(DEATH_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);

  logic [2:0]         state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               newGame_q, newGame_d;
  logic               respawn_q, respawn_d;
  logic [2:0]         press;

  key_edge #(
    .KEY_W (KEY_W),
    .CODE0 (KEY_START),
    .CODE1 (KEY_PAUSE),
    .CODE2 (KEY_ACK)
  ) u_key_edge (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .key_i   (bus.keyboard),
    .press_o (press)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    lives_d   = lives_q;
    newGame_d = 1'b0;
    respawn_d = 1'b0;
    case (state_q)
      S_START: begin
        if (press[0]) begin
          state_d   = S_PLAY;
          newGame_d = 1'b1;
          lives_d   = LIVES_INIT;
        end
      end
      S_PLAY: begin
        if (bus.pacDeath) begin
          state_d = S_DYING;
          timer_d = '0;
        end else if (bus.winsignal) begin
          state_d = S_WIN;
        end else if (press[1]) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (press[1]) begin
          state_d = S_PLAY;
        end
      end
      S_DYING: begin
        // The last life ends the game, so lives_left can never wrap below zero.
        if (timer_q == TMR_LAST) begin
          timer_d = '0;
          if (lives_q == LIVES_ONE) begin
            state_d = S_GAMEOVER;
            lives_d = '0;
          end else begin
            state_d   = S_PLAY;
            lives_d   = lives_q - LIVES_ONE;
            respawn_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_GAMEOVER, S_WIN: begin
        if (press[2]) begin
          state_d = S_START;
        end
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_START;
      timer_q   <= '0;
      lives_q   <= LIVES_INIT;
      newGame_q <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lives_q   <= lives_d;
      newGame_q <= newGame_d;
      respawn_q <= respawn_d;
    end
  end

  // Screen selects decode the registered state; an illegal code drives them all low.
  assign bus.startscreen    = (state_q == S_START);
  assign bus.gamescreen     = (state_q == S_PLAY) || (state_q == S_PAUSE) || (state_q == S_DYING);
  assign bus.pausescreen    = (state_q == S_PAUSE);
  assign bus.gameoverscreen = (state_q == S_GAMEOVER);
  assign bus.winscreen      = (state_q == S_WIN);
  assign bus.game_run       = (state_q == S_PLAY);
  assign bus.new_game       = newGame_q;
  assign bus.respawn        = respawn_q;
  assign bus.lives_left     = lives_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: default build plus a one-life, one-cycle-death build.
module tb_game_state_ctrl;

  // Flag order: {start, game, pause, gameover, win, run, new_game, respawn}
  localparam logic [7:0] F_START = 8'b1000_0000;
  localparam logic [7:0] F_PLAY  = 8'b0100_0100;
  localparam logic [7:0] F_NEW   = 8'b0100_0110;
  localparam logic [7:0] F_RESP  = 8'b0100_0101;
  localparam logic [7:0] F_PAUSE = 8'b0110_0000;
  localparam logic [7:0] F_DYING = 8'b0100_0000;
  localparam logic [7:0] F_OVER  = 8'b0001_0000;
  localparam logic [7:0] F_WIN   = 8'b0000_1000;

  typedef struct {
    string       name;
    logic [15:0] key;
    logic        death;
    logic        win;
    logic [7:0]  expFlags;
    logic [1:0]  expLives;
  } vec_t;

  logic Clk;
  logic Reset_n;
  int   assertCount;
  int   failCount;
  vec_t vecs[$];

  game_state_ctrl_if #(.KEY_W(16), .LIVES_W(2)) busA ();
  game_state_ctrl_if #(.KEY_W(16), .LIVES_W(2)) busB ();

  game_state_ctrl dutA (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (busA)
  );

  game_state_ctrl #(
    .LIVES        (1),
    .DEATH_CYCLES (1)
  ) dutB (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (busB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] flagsA();
    return {busA.startscreen, busA.gamescreen, busA.pausescreen, busA.gameoverscreen,
            busA.winscreen, busA.game_run, busA.new_game, busA.respawn};
  endfunction

  function automatic logic [7:0] flagsB();
    return {busB.startscreen, busB.gamescreen, busB.pausescreen, busB.gameoverscreen,
            busB.winscreen, busB.game_run, busB.new_game, busB.respawn};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] key, input logic death, input logic win);
    busA.keyboard  = key;
    busA.pacDeath  = death;
    busA.winsignal = win;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actFlags, input logic [1:0] actLives,
                             input logic [7:0] expFlags, input logic [1:0] expLives);
    assertCount++;
    if (actFlags !== expFlags || actLives !== expLives) begin
      failCount++;
      $display("[TB] FAIL %s: flags=%b lives=%0d, expected flags=%b lives=%0d",
               name, actFlags, actLives, expFlags, expLives);
    end
  endtask

  task automatic addVec(input string name, input logic [15:0] key, input logic death, input logic win,
                        input logic [7:0] expFlags, input logic [1:0] expLives);
    vec_t v;
    v.name = name; v.key = key; v.death = death; v.win = win;
    v.expFlags = expFlags; v.expLives = expLives;
    vecs.push_back(v);
  endtask

  task automatic runTable();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].key, vecs[i].death, vecs[i].win);
      checkOutput(vecs[i].name, flagsA(), busA.lives_left, vecs[i].expFlags, vecs[i].expLives);
    end
    vecs.delete();
  endtask

  // One full death sequence from the first DYING cycle; keys pressed meanwhile must be ignored.
  task automatic dyingRun(input string name, input logic [7:0] endFlags, input logic [1:0] endLives,
                          input logic [1:0] dyingLives);
    for (int c = 1; c < 60; c++) begin
      applyStimulus((c % 2) ? 16'h0029 : 16'h0000, 1'b0, 1'b0);
      if (c == 1 || c == 30 || c == 59)
        checkOutput({name, "_dying"}, flagsA(), busA.lives_left, F_DYING, dyingLives);
    end
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput({name, "_end"}, flagsA(), busA.lives_left, endFlags, endLives);
  endtask

  initial begin
    assertCount    = 0;
    failCount      = 0;
    Reset_n        = 1'b0;
    busA.keyboard  = '0;
    busA.pacDeath  = 1'b0;
    busA.winsignal = 1'b0;
    busB.keyboard  = '0;
    busB.pacDeath  = 1'b0;
    busB.winsignal = 1'b0;
    tick();
    tick();
    checkOutput("reset", flagsA(), busA.lives_left, F_START, 2'd3);
    Reset_n = 1'b1;
    tick();
    checkOutput("reset_release", flagsA(), busA.lives_left, F_START, 2'd3);

    // Start, hold Enter, pause toggling, pacDeath ignored while paused, then die with win also high.
    addVec("start_press", 16'h0028, 1'b0, 1'b0, F_NEW, 2'd3);
    for (int i = 0; i < 9; i++) addVec("start_held", 16'h0028, 1'b0, 1'b0, F_PLAY, 2'd3);
    addVec("play_idle",    16'h0000, 1'b0, 1'b0, F_PLAY,  2'd3);
    addVec("pause_press",  16'h0029, 1'b0, 1'b0, F_PAUSE, 2'd3);
    addVec("pause_held",   16'h0029, 1'b0, 1'b0, F_PAUSE, 2'd3);
    addVec("pause_death",  16'h0000, 1'b1, 1'b0, F_PAUSE, 2'd3);
    addVec("pause_win",    16'h0000, 1'b0, 1'b1, F_PAUSE, 2'd3);
    addVec("unpause",      16'h0029, 1'b0, 1'b0, F_PLAY,  2'd3);
    addVec("play_again",   16'h0000, 1'b0, 1'b0, F_PLAY,  2'd3);
    addVec("death_vs_win", 16'h0000, 1'b1, 1'b1, F_DYING, 2'd3);
    runTable();

    dyingRun("death1", F_RESP, 2'd2, 2'd3);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("respawn_clear", flagsA(), busA.lives_left, F_PLAY, 2'd2);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("death2_enter", flagsA(), busA.lives_left, F_DYING, 2'd2);
    dyingRun("death2", F_RESP, 2'd1, 2'd2);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("death3_enter", flagsA(), busA.lives_left, F_DYING, 2'd1);
    dyingRun("death3", F_OVER, 2'd0, 2'd1);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("gameover_hold", flagsA(), busA.lives_left, F_OVER, 2'd0);

    addVec("ack_gameover", 16'h002C, 1'b0, 1'b0, F_START, 2'd0);
    addVec("restart",      16'h0028, 1'b0, 1'b0, F_NEW,   2'd3);
    addVec("play_space",   16'h002C, 1'b0, 1'b0, F_PLAY,  2'd3);
    addVec("win_enter",    16'h002C, 1'b0, 1'b1, F_WIN,   2'd3);
    addVec("win_held_key", 16'h002C, 1'b0, 1'b0, F_WIN,   2'd3);
    addVec("win_release",  16'h0000, 1'b0, 1'b0, F_WIN,   2'd3);
    addVec("win_ack",      16'h002C, 1'b0, 1'b0, F_START, 2'd3);
    addVec("restart2",     16'h0028, 1'b0, 1'b0, F_NEW,   2'd3);
    addVec("death4_enter", 16'h0000, 1'b1, 1'b0, F_DYING, 2'd3);
    runTable();

    // Reset in the 30th cycle of DYING must return straight to START with no later pulse.
    for (int c = 1; c < 30; c++) applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("dying_c30", flagsA(), busA.lives_left, F_DYING, 2'd3);
    Reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_dying", flagsA(), busA.lives_left, F_START, 2'd3);
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0000, 1'b0, 1'b0);
      checkOutput("post_reset_quiet", flagsA(), busA.lives_left, F_START, 2'd3);
    end

    // One life, one death cycle.
    checkOutput("b_idle", flagsB(), busB.lives_left, F_START, 2'd1);
    busB.keyboard = 16'h0028;
    tick();
    checkOutput("b_start", flagsB(), busB.lives_left, F_NEW, 2'd1);
    busB.keyboard = 16'h0000;
    busB.pacDeath = 1'b1;
    tick();
    checkOutput("b_dying", flagsB(), busB.lives_left, F_DYING, 2'd1);
    busB.pacDeath = 1'b0;
    tick();
    checkOutput("b_gameover", flagsB(), busB.lives_left, F_OVER, 2'd0);
    busB.keyboard = 16'h002C;
    tick();
    checkOutput("b_ack", flagsB(), busB.lives_left, F_START, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Parametrised successor to the top-level screen FSM. Sequences Start -> Play -> {Pause, Dying, GameOver, Win} with a multi-life counter, a timed death sequence and edge-detected key commands. Sits between the keyboard decoder and the sprite, maze and ghost logic. Drives one-hot screen selects for the VGA colour mux and run/respawn/new-game strobes for the game datapath.

Parameters:
KEY_W, 16, width of keyboard scan-code input
KEY_START, 16'h0028, Enter: Start -> Play
KEY_PAUSE, 16'h0029, Esc: toggles Play <-> Pause
KEY_ACK, 16'h002C, Space: GameOver/Win -> Start
LIVES, 3, lives per new game (1..2**LIVES_W-1)
LIVES_W, 2, lives counter width
DEATH_CYCLES, 60, Clk cycles in Dying before resolving (>=1)
TMR_W, 8, timer width (2**TMR_W > DEATH_CYCLES)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous reset, active-low
keyboard  in  KEY_W  current scan code, 0 = no key
pacDeath  in  1  level, Pac-Man collided with ghost
winsignal  in  1  level, all pellets eaten
startscreen  out  1  Start state
gamescreen  out  1  Play, Pause or Dying (maze drawn)
pausescreen  out  1  Pause state (overlay)
gameoverscreen  out  1  GameOver state
winscreen  out  1  Win state
game_run  out  1  Play only; enables movement/ghost/pellet logic
new_game  out  1  one-cycle pulse on Start -> Play
respawn  out  1  one-cycle pulse on Dying -> Play
lives_left  out  LIVES_W  remaining lives for HUD

Behaviour:
- Interface: one clock Clk; Reset_n asynchronous, active-low. Everything below updates on posedge Clk only.
- Reset: state=START, lives_left=LIVES, timer=0, key_q=0. Outputs: startscreen=1, all other outputs 0.
- Key edge detect: key_q <= keyboard each cycle. press(K) = (keyboard==K) && (key_q!=K). Holding a key yields one command; re-press needs an intervening different code.
- START: on press(KEY_START) -> PLAY. Pulse new_game. lives_left <= LIVES.
- PLAY, priority highest first:
  - pacDeath -> DYING, timer <= 0
  - winsignal -> WIN
  - press(KEY_PAUSE) -> PAUSE
  - else stay
- PAUSE: on press(KEY_PAUSE) -> PLAY. pacDeath and winsignal are ignored.
- DYING: timer increments each cycle. When timer == DEATH_CYCLES-1:
  - lives_left==1 -> GAMEOVER, lives_left <= 0
  - else -> PLAY, lives_left decrements, pulse respawn
  - Keys ignored during DYING.
- GAMEOVER, WIN: on press(KEY_ACK) -> START. lives_left is held until the next new_game.
- Outputs:
  - Moore decode of registered state, except new_game/respawn, which are registered pulses asserted in the first cycle of the new PLAY state.
  - Exactly one of {startscreen, gamescreen, gameoverscreen, winscreen} is high at all times.
  - pausescreen implies gamescreen.
- Illegal state encoding -> START next cycle; all outputs 0 while illegal.
- Reset_n low mid-operation (any state, including mid-DYING) returns to the reset values immediately. No pulse is emitted on reset release.
- lives_left never underflows; decrement is guarded by the lives_left==1 check.

Decomposition:
- Package game_pkg: state enum (START, PLAY, PAUSE, DYING, GAMEOVER, WIN, 3-bit), default key-code localparams KEY_ENTER/KEY_ESC/KEY_SPACE.
- Sub-module key_edge: registers keyboard and outputs press strobes for three codes. Parametrised by KEY_W and the three codes; reused by menu logic.

Test Plan:
- Reset_n=0 then 1, keyboard=0 -> startscreen=1, lives_left=3, all strobes 0. Hold keyboard=16'h28 for 10 cycles -> one new_game pulse, PLAY from next cycle, game_run=1.
- In PLAY: pulse keyboard=16'h29, release, pulse again -> PAUSE (pausescreen=1, gamescreen=1, game_run=0), then back to PLAY. pacDeath=1 during PAUSE has no effect.
- In PLAY, pacDeath=1 one cycle -> DYING for exactly 60 cycles, then PLAY with respawn=1 and lives_left=2. Repeat twice -> GAMEOVER with lives_left=0. keyboard=16'h2C -> START.
- In PLAY, pacDeath=1 and winsignal=1 in the same cycle -> DYING, not WIN. winsignal alone -> WIN. Holding 16'h2C from before entering WIN does not exit until released and re-pressed.
- Reset_n asserted at cycle 30 of DYING -> immediate START, lives_left=3. No respawn pulse after release.
- DEATH_CYCLES=1, LIVES=1 build: pacDeath -> DYING for 1 cycle -> GAMEOVER.
